// File: rtl/neuron_mac_acc.sv
// Per-neuron multiply-accumulate: streams weights against packed activations,
// adds bias, rescales, saturates, optional ReLU, valid/ready output.
// Ports: clk, rst (async high), mac_en beat strobe, weight_in, act_in packed,
//   bias, result/out_valid/out_ready handshake, busy, err (sticky).
module neuron_mac_acc #(
  parameter int weight_n   = 5,
  parameter int data_width = 16,
  parameter int frac_bits  = 8,
  parameter bit relu_en    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mac_en,
  input  logic [data_width-1:0]          weight_in,
  input  logic [data_width*weight_n-1:0] act_in,
  input  logic [data_width-1:0]          bias,
  output logic [data_width-1:0]          result,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           err
);

  localparam int DW = data_width;
  localparam int PW = 2 * DW;
  localparam int AW = PW + $clog2(weight_n) + 1;
  localparam int CW = (weight_n > 1) ? $clog2(weight_n) : 1;
  localparam logic [CW-1:0] LAST = CW'(weight_n - 1);
  localparam bit ONE_BEAT = (weight_n == 1);

  typedef enum logic [1:0] {
    IDLE, ACCUM, FINISH, OUT
  } state_t;

  state_t state, state_n;

  logic signed [AW-1:0] acc, acc_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DW-1:0]        result_n;
  logic                 valid_n;
  logic                 err_n;

  logic signed [DW-1:0] act_sel;
  logic signed [DW-1:0] w_s;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;
  logic signed [AW-1:0] bias_x;
  logic signed [AW-1:0] s;
  logic signed [AW-1:0] r;
  logic signed [AW-1:0] maxv;
  logic signed [AW-1:0] minv;
  logic [DW-1:0]        sat;

  assign act_sel = act_in[int'(cnt)*DW +: DW];
  assign w_s     = weight_in;
  assign prod    = w_s * act_sel;
  assign prod_x  = {{(AW-PW){prod[PW-1]}}, prod};
  assign bias_x  = {{(AW-DW){bias[DW-1]}}, bias};

  // Bias is aligned to the product's 2*frac_bits scale before the shift.
  assign s    = acc + (bias_x <<< frac_bits);
  assign r    = s >>> frac_bits;
  assign maxv = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  assign minv = ~maxv;

  always_comb begin
    sat = r[DW-1:0];
    if (r > maxv)      sat = maxv[DW-1:0];
    else if (r < minv) sat = minv[DW-1:0];
    if (relu_en && r[AW-1]) sat = '0;
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    result_n = result;
    valid_n  = out_valid;
    err_n    = err;
    unique case (state)
      IDLE: begin
        if (mac_en) begin
          acc_n   = prod_x;
          cnt_n   = ONE_BEAT ? '0 : CW'(1);
          state_n = ONE_BEAT ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (mac_en) begin
          acc_n = acc + prod_x;
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = FINISH;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      FINISH: begin
        if (mac_en) err_n = 1'b1;
        result_n = sat;
        valid_n  = 1'b1;
        state_n  = OUT;
      end
      OUT: begin
        if (out_ready) begin
          valid_n = 1'b0;
          // A beat in the hand-off cycle starts the next pass directly.
          if (mac_en) begin
            acc_n   = prod_x;
            cnt_n   = ONE_BEAT ? '0 : CW'(1);
            state_n = ONE_BEAT ? FINISH : ACCUM;
          end else begin
            state_n = IDLE;
          end
        end else if (mac_en) begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      result    <= result_n;
      out_valid <= valid_n;
      err       <= err_n;
    end
  end

  assign busy = (state == ACCUM) || (state == FINISH);

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc: table of single-pass vectors checked
// on a ReLU and a linear instance, plus stall/back-pressure/reset sequences.
module tb_neuron_mac_acc;

  localparam int N  = 5;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            mac_en;
  logic [DW-1:0]   weight_in;
  logic [DW*N-1:0] act_in;
  logic [DW-1:0]   bias;
  logic            out_ready;

  logic [DW-1:0] result_r, result_l;
  logic          valid_r, valid_l;
  logic          busy_r, busy_l;
  logic          err_r, err_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_mac_acc #(
    .weight_n(N), .data_width(DW), .frac_bits(8), .relu_en(1'b1)
  ) dut_relu (
    .clk(clk), .rst(rst), .mac_en(mac_en), .weight_in(weight_in),
    .act_in(act_in), .bias(bias), .result(result_r),
    .out_valid(valid_r), .out_ready(out_ready), .busy(busy_r), .err(err_r)
  );

  neuron_mac_acc #(
    .weight_n(N), .data_width(DW), .frac_bits(8), .relu_en(1'b0)
  ) dut_lin (
    .clk(clk), .rst(rst), .mac_en(mac_en), .weight_in(weight_in),
    .act_in(act_in), .bias(bias), .result(result_l),
    .out_valid(valid_l), .out_ready(out_ready), .busy(busy_l), .err(err_l)
  );

  typedef struct {
    logic [DW-1:0] w;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_relu;
    logic [DW-1:0] exp_lin;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n, input logic [DW-1:0] w);
    mac_en    = 1'b1;
    weight_in = w;
    for (int i = 0; i < n; i++) tick();
    mac_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0100, 16'h0100, 16'h0080, 16'h0580, 16'h0580};
    vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    vecs[3] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0000, 16'hFB00};
    vecs[4] = '{16'h0080, 16'h0200, 16'hFF00, 16'h0400, 16'h0400};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};

    rst = 1'b1; mac_en = 1'b0; weight_in = '0;
    act_in = '0; bias = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_result", result_r, 0);
    check("rst_valid", valid_r, 0);
    check("rst_busy", busy_r, 0);
    check("rst_err", err_r, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      act_in = {N{vecs[v].a}};
      bias   = vecs[v].b;
      beats(N, vecs[v].w);
      check($sformatf("v%0d_busy_finish", v), busy_r, 1);
      check($sformatf("v%0d_valid_early", v), valid_r, 0);
      tick();
      check($sformatf("v%0d_valid", v), valid_r, 1);
      check($sformatf("v%0d_relu", v), result_r, vecs[v].exp_relu);
      check($sformatf("v%0d_lin", v), result_l, vecs[v].exp_lin);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_valid_drop", v), valid_r, 0);
      check($sformatf("v%0d_idle", v), busy_r, 0);
    end

    act_in = {N{16'h0100}};
    bias   = 16'h0080;
    beats(2, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", busy_r, 1);
      check("stall_valid", valid_r, 0);
    end
    beats(3, 16'h0100);
    tick();
    check("stall_valid", valid_r, 1);
    check("stall_result", result_r, 16'h0580);
    check("stall_err", err_r, 0);

    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", valid_r, 1);
      check("bp_hold_result", result_r, 16'h0580);
    end
    bias = 16'h0000;
    out_ready = 1'b1;
    beats(1, 16'h0200);
    out_ready = 1'b0;
    check("b2b_valid_drop", valid_r, 0);
    check("b2b_busy", busy_r, 1);
    beats(4, 16'h0200);
    tick();
    check("b2b_valid", valid_r, 1);
    check("b2b_result", result_r, 16'h0A00);
    check("b2b_err", err_r, 0);
    beats(1, 16'h0100);
    check("bp_err", err_r, 1);
    check("bp_err_valid", valid_r, 1);
    check("bp_err_result", result_r, 16'h0A00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_take_valid", valid_r, 0);
    check("err_sticky", err_r, 1);

    bias = 16'h0080;
    beats(3, 16'h0100);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy_r, 0);
    check("mid_rst_err", err_r, 0);
    check("mid_rst_valid", valid_r, 0);
    check("mid_rst_result", result_r, 0);
    tick();
    rst = 1'b0;
    tick();
    beats(N, 16'h0100);
    tick();
    check("post_rst_valid", valid_r, 1);
    check("post_rst_result", result_r, 16'h0580);
    check("post_rst_err", err_r, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    beats(N + 1, 16'h0100);
    check("fin_err", err_r, 1);
    check("fin_valid", valid_r, 1);
    check("fin_result", result_r, 16'h0580);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
